// File: rtl/eqn_seq_cmp_amisha_pkg.sv
// Shared types and helpers for the digit-serial comparator.
package eqn_cmp_pkg_amisha;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the digit index / counter; at least one bit even when N = 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eqn_seq_cmp_amisha_slice.sv
// Combinational DIGIT-wide compare slice: equality and unsigned greater-than.
module cmp_slice_amisha #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_digit,
  input  logic [DIGIT-1:0] b_digit,
  output logic             slice_eq,
  output logic             slice_gt
);

  logic [DIGIT-1:0] bit_eq;

  // One XNOR equality cell per bit.
  for (genvar i = 0; i < DIGIT; i++) begin : g_eq_cell
    assign bit_eq[i] = ~(a_digit[i] ^ b_digit[i]);
  end

  assign slice_eq = &bit_eq;

  // Greater-than chain walked LSB to MSB so the most significant difference wins.
  always_comb begin
    slice_gt = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_gt = (a_digit[i] & ~b_digit[i]) | (bit_eq[i] & slice_gt);
    end
  end

endmodule

// File: rtl/eqn_seq_cmp_amisha.sv
// Digit-serial unsigned comparator, MSB digit first, with start/busy/done handshake.
module eqn_seq_cmp_amisha
  import eqn_cmp_pkg_amisha::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 1,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic                                 clk_amisha,
  input  logic                                 rst_n_amisha,
  input  logic                                 start_amisha,
  input  logic [WIDTH-1:0]                     a_amisha,
  input  logic [WIDTH-1:0]                     b_amisha,
  output logic                                 busy_amisha,
  output logic                                 done_amisha,
  output logic                                 eq_amisha,
  output logic                                 gt_amisha,
  output logic                                 lt_amisha,
  output logic [idx_width(WIDTH/DIGIT)-1:0]    diff_idx_amisha
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e          state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [IW-1:0]   cnt;
  logic            decided;
  logic            dec_gt;
  logic [IW-1:0]   dec_idx;

  logic            slice_eq, slice_gt;
  logic            hit_now, gt_now, finish, accept;
  logic [IW-1:0]   idx_now;

  // Operands are shifted left each RUN cycle, so the current digit (digit[cnt])
  // always sits in the top DIGIT bits; cnt only tracks its index.
  cmp_slice_amisha #(.DIGIT(DIGIT)) u_slice (
    .a_digit  (a_sh[WIDTH-1 -: DIGIT]),
    .b_digit  (b_sh[WIDTH-1 -: DIGIT]),
    .slice_eq (slice_eq),
    .slice_gt (slice_gt)
  );

  // Decision including the current digit; an earlier difference is never overridden.
  always_comb begin
    hit_now = decided | ~slice_eq;
    gt_now  = decided ? dec_gt  : slice_gt;
    idx_now = decided ? dec_idx : cnt;
    finish  = (cnt == '0) | (EARLY_EXIT & ~slice_eq);
    accept  = start_amisha & ((state == IDLE) | (state == DONE));
  end

  // State register.
  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) state <= IDLE;
    else               state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_amisha ? RUN : IDLE;
      RUN:     state_nx = finish ? DONE : RUN;
      DONE:    state_nx = start_amisha ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy_amisha = (state == RUN);
    done_amisha = (state == DONE);
  end

  // Operand, counter, running-decision and result registers. The running
  // decision is kept internally so eq/gt/lt stay 0 throughout RUN and are
  // published only on the transition into DONE.
  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) begin
      a_sh            <= '0;
      b_sh            <= '0;
      cnt             <= '0;
      decided         <= 1'b0;
      dec_gt          <= 1'b0;
      dec_idx         <= '0;
      eq_amisha       <= 1'b0;
      gt_amisha       <= 1'b0;
      lt_amisha       <= 1'b0;
      diff_idx_amisha <= '0;
    end else if (accept) begin
      a_sh            <= a_amisha;
      b_sh            <= b_amisha;
      cnt             <= LAST;
      decided         <= 1'b0;
      dec_gt          <= 1'b0;
      dec_idx         <= '0;
      eq_amisha       <= 1'b0;
      gt_amisha       <= 1'b0;
      lt_amisha       <= 1'b0;
      diff_idx_amisha <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh << DIGIT;
      b_sh    <= b_sh << DIGIT;
      decided <= hit_now;
      dec_gt  <= gt_now;
      dec_idx <= idx_now;
      if (finish) begin
        eq_amisha       <= ~hit_now;
        gt_amisha       <= hit_now & gt_now;
        lt_amisha       <= hit_now & ~gt_now;
        diff_idx_amisha <= hit_now ? idx_now : '0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eqn_seq_cmp_amisha.sv
// Directed bench: three comparator configurations share one stimulus stream.
module tb_eqn_seq_cmp_amisha;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;

  logic [2:0] dn, bsy;
  logic [5:0] res [3];   // {eq, gt, lt, diff_idx[2:0]}

  logic e0, g0, l0, e1, g1, l1, e2, g2, l2;
  logic [2:0] i0, i1;
  logic [0:0] i2;

  int total = 0;
  int bad   = 0;

  int lat    [3];
  int pulses [3];
  logic [5:0] got [3];
  int busy_cnt;

  always #5 clk = ~clk;

  // W=8, D=1, constant latency
  eqn_seq_cmp_amisha #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b0)) u0 (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
    .a_amisha(a), .b_amisha(b), .busy_amisha(bsy[0]), .done_amisha(dn[0]),
    .eq_amisha(e0), .gt_amisha(g0), .lt_amisha(l0), .diff_idx_amisha(i0));

  // W=8, D=1, early exit
  eqn_seq_cmp_amisha #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u1 (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
    .a_amisha(a), .b_amisha(b), .busy_amisha(bsy[1]), .done_amisha(dn[1]),
    .eq_amisha(e1), .gt_amisha(g1), .lt_amisha(l1), .diff_idx_amisha(i1));

  // W=8, D=4, constant latency
  eqn_seq_cmp_amisha #(.WIDTH(8), .DIGIT(4), .EARLY_EXIT(1'b0)) u2 (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
    .a_amisha(a), .b_amisha(b), .busy_amisha(bsy[2]), .done_amisha(dn[2]),
    .eq_amisha(e2), .gt_amisha(g2), .lt_amisha(l2), .diff_idx_amisha(i2));

  assign res[0] = {e0, g0, l0, i0};
  assign res[1] = {e1, g1, l1, i1};
  assign res[2] = {e2, g2, l2, 2'b00, i2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pulsed start, then a fixed 12-cycle window recording each instance's
  // first done latency (edges after the accepting edge), pulse count and result.
  task automatic run_op(input logic [7:0] na, input logic [7:0] nb, input bit scramble);
    a = na; b = nb; start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin a = 8'hFF; b = 8'hFF; end
    busy_cnt = bsy[0] ? 1 : 0;
    for (int k = 0; k < 3; k++) begin lat[k] = -1; pulses[k] = 0; got[k] = '0; end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bsy[0]) busy_cnt++;
      for (int k = 0; k < 3; k++) begin
        if (dn[k]) begin
          pulses[k]++;
          if (lat[k] < 0) begin lat[k] = c; got[k] = res[k]; end
        end
      end
    end
  endtask

  task automatic expect_op(input string tag,
                           input int l0x, input int l1x, input int l2x,
                           input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2);
    int le [3];
    logic [5:0] re [3];
    le[0] = l0x; le[1] = l1x; le[2] = l2x;
    re[0] = r0;  re[1] = r1;  re[2] = r2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_u%0d_lat", tag, k), lat[k], le[k]);
      check($sformatf("%s_u%0d_pulses", tag, k), pulses[k], 1);
      check($sformatf("%s_u%0d_res", tag, k), {26'd0, got[k]}, {26'd0, re[k]});
    end
  endtask

  int         n;
  int         tdone [3];
  logic [5:0] rb    [3];
  int         extra;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_u%0d", k), {24'd0, bsy[k], dn[k], res[k]}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Equal operands
    run_op(8'hA5, 8'hA5, 1'b0);
    check("eq_busy_cycles", busy_cnt, 8);
    expect_op("eqA5", 8, 8, 2, 6'b100_000, 6'b100_000, 6'b100_000);

    // MSB difference, both orders
    run_op(8'h80, 8'h7F, 1'b0);
    expect_op("gt80", 8, 1, 2, 6'b010_111, 6'b010_111, 6'b010_001);
    run_op(8'h7F, 8'h80, 1'b0);
    expect_op("lt7F", 8, 1, 2, 6'b001_111, 6'b001_111, 6'b001_001);

    // LSB-only difference: early exit must still scan all digits
    run_op(8'h01, 8'h00, 1'b0);
    expect_op("gt01", 8, 8, 2, 6'b010_000, 6'b010_000, 6'b010_000);

    // Operands changed after capture
    run_op(8'h3C, 8'h3D, 1'b1);
    expect_op("lt3C", 8, 8, 2, 6'b001_000, 6'b001_000, 6'b001_000);
    check("hold_after_done", {26'd0, res[0]}, {26'd0, 6'b001_000});

    // start held high over three back-to-back operations on u0
    a = 8'h10; b = 8'h10; start = 1'b1;
    tick();
    n = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      tick();
      if (dn[0]) begin
        tdone[n] = c; rb[n] = res[0]; n++;
        if (n == 1) begin a = 8'h20; b = 8'h10; end
        else if (n == 2) begin a = 8'h00; b = 8'hFF; end
        else start = 1'b0;
      end
    end
    check("b2b_count", n, 3);
    check("b2b_t0", tdone[0], 8);
    check("b2b_t1", tdone[1], 17);
    check("b2b_t2", tdone[2], 26);
    check("b2b_r0", {26'd0, rb[0]}, {26'd0, 6'b100_000});
    check("b2b_r1", {26'd0, rb[1]}, {26'd0, 6'b010_101});
    check("b2b_r2", {26'd0, rb[2]}, {26'd0, 6'b001_111});
    start = 1'b0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (dn[0]) extra++; end
    check("b2b_no_extra", extra, 0);

    // Reset in the middle of RUN
    a = 8'h80; b = 8'h7F; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("midrun_busy", {31'd0, bsy[0]}, 32'd1);
    rst_n = 1'b0;
    tick();
    for (int k = 0; k < 3; k++)
      check($sformatf("midrun_reset_u%0d", k), {24'd0, bsy[k], dn[k], res[k]}, 32'd0);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (dn[0] | dn[1] | dn[2]) extra++; end
    check("midrun_no_done", extra, 0);
    run_op(8'h80, 8'h7F, 1'b0);
    expect_op("post_reset", 8, 1, 2, 6'b010_111, 6'b010_111, 6'b010_001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eqn_seq_cmp_amisha.md
Name: eqn_seq_cmp_amisha

Overview:
Parametrised, sequential successor to the team's 1-bit gate-level equality cell. It compares two WIDTH-bit operands digit-serially, MSB digit first, DIGIT bits per clock. It reports eq/gt/lt plus the index of the most significant differing digit. A start/busy/done handshake lets it sit beside datapath blocks that cannot afford a full-width parallel comparator.

Parameters:
- WIDTH, 8: operand width in bits; must be ≥ 1.
- DIGIT, 1: bits compared per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT digits.
- EARLY_EXIT, 0: 1 = finish at the first differing digit; 0 = always take N cycles (constant latency).

Ports:
- clk_amisha, in, 1: single clock, rising edge.
- rst_n_amisha, in, 1: synchronous, active-low reset.
- start_amisha, in, 1: request; sampled only when not busy.
- a_amisha, in, WIDTH: operand A; captured on accepted start.
- b_amisha, in, WIDTH: operand B; captured on accepted start.
- busy_amisha, out, 1: high while in RUN.
- done_amisha, out, 1: one-cycle pulse; results valid in this cycle.
- eq_amisha, out, 1: A == B.
- gt_amisha, out, 1: A > B (unsigned).
- lt_amisha, out, 1: A < B (unsigned).
- diff_idx_amisha, out, max(1,clog2(N)): index of the most significant differing digit (digit N-1 = MSB digit); 0 when eq.

Behaviour:
- Reset (rst_n_amisha low at a rising edge):
  - state = IDLE; busy, done, eq, gt, lt and diff_idx all 0.
  - Internal operand registers and digit counter are cleared.
  - Reset wins over every other input.
  - Reset during RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 → capture a/b, set counter = N-1, clear eq/gt/lt/diff_idx, go to RUN.
  - start = 0 → stay in IDLE.
- RUN:
  - busy = 1; start is ignored.
  - Each cycle, compare digit[counter] of A against digit[counter] of B.
  - First differing digit: latch gt = (A digit > B digit), lt = the inverse, diff_idx = counter, and set a "decided" flag. Later digits never change the latched result.
  - EARLY_EXIT = 1 and the current digit differs → go to DONE.
  - Counter = 0 → go to DONE, with eq = !decided.
  - Otherwise decrement the counter.
- DONE:
  - done = 1 for exactly this one cycle.
  - Next state is IDLE, or RUN if start = 1 in this cycle (back-to-back accept, new operands captured).
- Result hold: eq/gt/lt/diff_idx stay stable from DONE until the next accepted start, which clears them.
- Invariants: exactly one of eq/gt/lt is high whenever a result is valid; all three are 0 after reset or during RUN.
- Latency, start sampled at edge k:
  - EARLY_EXIT = 0: done is high in the cycle after edge k+N.
  - EARLY_EXIT = 1: done is high in the cycle after edge k+m, where m = number of digits examined (1..N).
- Throughput: one comparison per N+1 cycles, back-to-back.
- Boundary cases:
  - N = 1: one RUN cycle.
  - WIDTH = DIGIT: fully parallel, 2-cycle op.
  - Operand changes on a_amisha/b_amisha after capture have no effect.
  - start held high continuously gives repeated operations with no idle gap.

Decomposition:
- Package eqn_cmp_pkg_amisha:
  - state encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - function computing the diff_idx width.
- Sub-module cmp_slice_amisha (combinational, DIGIT-wide):
  - outputs slice_eq and slice_gt;
  - slice_eq is built from DIGIT replicated 1-bit XNOR-style equality cells, slice_gt from an MSB-priority chain.
- Top level holds the FSM, operand/counter registers and result registers.

Test Plan:
- WIDTH=8, DIGIT=1, EARLY_EXIT=0; a=0xA5, b=0xA5, start 1 cycle → busy for 8 cycles, done 9 cycles after start; eq=1, gt=lt=0, diff_idx=0.
- Same config; a=0x80, b=0x7F → done 9 cycles after start; gt=1, diff_idx=7. Swap operands → lt=1, diff_idx=7.
- EARLY_EXIT=1, WIDTH=8, DIGIT=1; a=0x80, b=0x7F → done 1 cycle after the single RUN cycle, gt=1, diff_idx=7. Then a=0x01, b=0x00 → done after 8 RUN cycles, gt=1, diff_idx=0.
- WIDTH=8, DIGIT=4; a=0x3C, b=0x3D → 2 RUN cycles; lt=1, diff_idx=0. Change a/b mid-run to 0xFF → result unchanged.
- start held high over 3 operations (0x10 vs 0x10, 0x20 vs 0x10, 0x00 vs 0xFF) → done pulses exactly every 9 cycles; results eq, gt, lt in order. start during busy is ignored.
- Deassert rst_n_amisha at RUN cycle 4 → next cycle all outputs 0, no done pulse; a fresh start afterwards completes normally.
